// File: rtl/keccak_squeeze.sv
// Squeeze controller for the Keccak-f[1600] sponge: streams the rate lanes as
// 64-bit words and hands the state back to the permutation when the rate runs out.
module keccak_squeeze #(
    parameter int RATE_LANES = 21,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_words,
    input  logic [1599:0]    state_in,
    output logic             perm_req,
    output logic [1599:0]    perm_state_out,
    input  logic             perm_done,
    input  logic [1599:0]    perm_state_in,
    output logic [63:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    // state     | meaning
    // IDLE      | waiting for start; num_words=0 completes immediately
    // EMIT      | presenting lane L of S on the output stream
    // PERM_REQ  | one-cycle perm_req with S on perm_state_out
    // PERM_WAIT | holding perm_state_out until perm_done reloads S
    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        PERM_REQ,
        PERM_WAIT
    } state_t;

    localparam logic [4:0]       LAST_LANE = 5'(RATE_LANES - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);

    state_t              st;
    logic [24:0][63:0]   s;
    logic [4:0]          lane;
    logic [CNT_W-1:0]    remain;

    logic [24:0][63:0]   in_lanes;
    logic [24:0][63:0]   perm_lanes;
    logic [4:0]          lane_nxt;

    assign in_lanes   = state_in;
    assign perm_lanes = perm_state_in;
    assign lane_nxt   = lane + 5'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st             <= IDLE;
            s              <= '0;
            lane           <= '0;
            remain         <= '0;
            perm_req       <= 1'b0;
            perm_state_out <= '0;
            out_data       <= '0;
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            perm_req <= 1'b0;
            done     <= 1'b0;
            case (st)
                IDLE: begin
                    if (start) begin
                        if (num_words == '0) begin
                            done <= 1'b1;
                        end else begin
                            s         <= in_lanes;
                            remain    <= num_words;
                            lane      <= '0;
                            out_data  <= in_lanes[0];
                            out_last  <= (num_words == ONE);
                            out_valid <= 1'b1;
                            busy      <= 1'b1;
                            st        <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        remain <= remain - ONE;
                        lane   <= lane_nxt;
                        if (remain == ONE) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            st        <= IDLE;
                        end else if (lane == LAST_LANE) begin
                            // Rate exhausted with words still owed: re-permute.
                            out_valid      <= 1'b0;
                            out_last       <= 1'b0;
                            perm_req       <= 1'b1;
                            perm_state_out <= s;
                            st             <= PERM_REQ;
                        end else begin
                            out_data <= s[lane_nxt];
                            out_last <= (remain == TWO);
                        end
                    end
                end
                PERM_REQ: begin
                    st <= PERM_WAIT;
                end
                PERM_WAIT: begin
                    if (perm_done) begin
                        s         <= perm_lanes;
                        lane      <= '0;
                        out_data  <= perm_lanes[0];
                        out_last  <= (remain == ONE);
                        out_valid <= 1'b1;
                        st        <= EMIT;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule
